// File: rtl/ex_stage_pkg.sv
// ex_pkg: shared op codes, forward selects, FSM states and multiply length for the EX stage
package ex_pkg;
    localparam int MUL_CYCLES = 32;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_NOR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
endpackage

// File: rtl/ex_stage_mul_iter.sv
// mul_iter: iterative shift-add multiplier returning the low word of the product
module mul_iter #(
    parameter int N  = 32,
    parameter int CW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          step_i,
    input  logic [31:0]   a_i,
    input  logic [31:0]   b_i,
    output logic [CW-1:0] count_o,
    output logic [31:0]   product_o
);
    logic [31:0] r_a, r_b, r_acc;
    assign product_o = r_acc + (r_b[0] ? r_a : 32'd0);
    // load operands on start, then add-and-shift once per step
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            count_o <= '0;
        end else if (start_i) begin
            r_a     <= a_i;
            r_b     <= b_i;
            r_acc   <= '0;
            count_o <= '0;
        end else if (step_i) begin
            r_a     <= r_a << 1;
            r_b     <= r_b >> 1;
            r_acc   <= product_o;
            count_o <= count_o + 1'b1;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: forwarding, ALU, iterative multiply control and EX/MEM pipeline register
module ex_stage #(
    parameter int MUL_CYCLES = ex_pkg::MUL_CYCLES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_ex_valid_i,
    input  logic [31:0] id_ex_rs_data_i,
    input  logic [31:0] id_ex_rt_data_i,
    input  logic [31:0] id_ex_imm_i,
    input  logic [4:0]  id_ex_shamt_i,
    input  logic [3:0]  id_ex_alu_op_i,
    input  logic        id_ex_alusrc_i,
    input  logic [4:0]  id_ex_rd_i,
    input  logic        id_ex_regwrite_i,
    input  logic        id_ex_memread_i,
    input  logic        id_ex_memwrite_i,
    input  logic        id_ex_memtoreg_i,
    input  logic [1:0]  forwardA_i,
    input  logic [1:0]  forwardB_i,
    input  logic [31:0] mem_wb_data_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        ex_mem_valid_o,
    output logic        ex_mem_regwrite_o,
    output logic        ex_mem_memread_o,
    output logic        ex_mem_memwrite_o,
    output logic        ex_mem_memtoreg_o,
    output logic [31:0] ex_mem_alu_result_o,
    output logic [31:0] ex_mem_rt_data_o,
    output logic [4:0]  ex_mem_rd_o
);
    import ex_pkg::*;
    localparam int CW = $clog2(MUL_CYCLES);
    state_t r_state, w_next;
    logic [31:0] w_a, w_b_fwd, w_b, w_alu, w_product;
    logic [CW-1:0] w_count;
    logic w_start, w_final, w_bubble;
    assign w_a = forwardA_i == FWD_EXMEM ? ex_mem_alu_result_o :
                 forwardA_i == FWD_MEMWB ? mem_wb_data_i : id_ex_rs_data_i;
    assign w_b_fwd = forwardB_i == FWD_EXMEM ? ex_mem_alu_result_o :
                     forwardB_i == FWD_MEMWB ? mem_wb_data_i : id_ex_rt_data_i;
    assign w_b = id_ex_alusrc_i ? id_ex_imm_i : w_b_fwd;
    assign w_start = r_state == S_IDLE && id_ex_valid_i && !flush_i && id_ex_alu_op_i == OP_MUL;
    assign w_final = r_state == S_BUSY && w_count == CW'(MUL_CYCLES - 1);
    assign w_bubble = r_state == S_BUSY ? !w_final
                                        : (!id_ex_valid_i || flush_i || id_ex_alu_op_i == OP_MUL);
    // single-cycle ALU; MUL and unused codes give 0 here
    always_comb begin
        w_alu = '0;
        case (id_ex_alu_op_i)
            OP_ADD:  w_alu = w_a + w_b;
            OP_SUB:  w_alu = w_a - w_b;
            OP_AND:  w_alu = w_a & w_b;
            OP_OR:   w_alu = w_a | w_b;
            OP_SLT:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
            OP_SLL:  w_alu = w_b << id_ex_shamt_i;
            OP_SRL:  w_alu = w_b >> id_ex_shamt_i;
            OP_NOR:  w_alu = ~(w_a | w_b);
            default: w_alu = '0;
        endcase
    end
    // next state and stall: stall covers the issue cycle and every busy step but the last
    always_comb begin
        w_next  = r_state;
        stall_o = 1'b0;
        if (r_state == S_IDLE) begin
            w_next  = w_start ? S_BUSY : S_IDLE;
            stall_o = w_start;
        end else begin
            w_next  = w_final ? S_IDLE : S_BUSY;
            stall_o = !w_final;
        end
    end
    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end
    mul_iter #(.N(MUL_CYCLES), .CW(CW)) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (w_start),
        .step_i    (r_state == S_BUSY),
        .a_i       (w_a),
        .b_i       (w_b),
        .count_o   (w_count),
        .product_o (w_product)
    );
    // EX/MEM register: bubble, ALU result, or the finished product on the last step
    always_ff @(posedge clk_i) begin
        if (rst_i || w_bubble) begin
            ex_mem_valid_o      <= 1'b0;
            ex_mem_regwrite_o   <= 1'b0;
            ex_mem_memread_o    <= 1'b0;
            ex_mem_memwrite_o   <= 1'b0;
            ex_mem_memtoreg_o   <= 1'b0;
            ex_mem_rd_o         <= '0;
            ex_mem_alu_result_o <= '0;
            ex_mem_rt_data_o    <= '0;
        end else begin
            ex_mem_valid_o      <= 1'b1;
            ex_mem_regwrite_o   <= id_ex_regwrite_i;
            ex_mem_memread_o    <= id_ex_memread_i;
            ex_mem_memwrite_o   <= id_ex_memwrite_i;
            ex_mem_memtoreg_o   <= id_ex_memtoreg_i;
            ex_mem_rd_o         <= id_ex_rd_i;
            ex_mem_alu_result_o <= w_final ? w_product : w_alu;
            ex_mem_rt_data_o    <= w_final ? 32'd0 : w_b_fwd;
        end
    end
endmodule
